key_scheduler_inverse_sequential: RTL and testbench

Inverse (decryption-order) AES-256 key scheduler. It is loaded once with the last two round keys, expanded words w52..w59. It then regenerates and emits round keys in descending order, round 14 down to round 0, one 128-bit key per accepted handshake. It sits in front of the AES decryption datapath and is the reverse-direction counterpart of the forward sequential N-word key scheduler.

---
 rtl/key_scheduler_inverse_sequential.sv | 178 +++++++++++++++++
 tb/tb_key_scheduler_inverse_sequential.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_scheduler_inverse_sequential.sv
// Inverse AES-256 key scheduler: loaded with w52..w59, it
// regenerates and emits round keys 14 down to 0, one per handshake.
module key_scheduler_inverse_sequential #(
  parameter int NB_BYTE       = 8,
  parameter int N_BYTES_WORD  = 4,
  parameter int NB_WORD       = N_BYTES_WORD*NB_BYTE,
  parameter int N_BYTES_KEY   = 32,
  parameter int N_BYTES_STATE = 16,
  parameter int N_ROUNDS      = 14,
  parameter int NB_INDEX      = 4
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_load,
  input  logic [8*NB_WORD-1:0]         i_key_tail_bus,
  input  logic                         i_ready,
  output logic [N_BYTES_STATE*NB_BYTE-1:0] o_round_key,
  output logic [NB_INDEX-1:0]          o_round_index,
  output logic                         o_valid,
  output logic                         o_last
);

  localparam int NB_WIN = 8*NB_WORD;
  localparam int NB_KEY = N_BYTES_STATE*NB_BYTE;
  localparam int N_KW   = N_BYTES_STATE/N_BYTES_WORD;
  localparam int NB_SRC = NB_KEY + NB_WORD;

  if (N_BYTES_KEY != 32) begin : g_bad_key
    $error("N_BYTES_KEY must be 32");
  end

  if (N_ROUNDS >= (1 << NB_INDEX)) begin : g_bad_index
    $error("NB_INDEX too narrow for N_ROUNDS");
  end

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t                state;
  logic [NB_WIN-1:0]     window;
  logic [NB_INDEX-1:0]   index;
  logic                  valid;
  logic                  last;

  logic [NB_SRC-1:0]     src;
  logic [NB_WORD-1:0]    t_first;
  logic [NB_WORD-1:0]    gen [N_KW];
  logic [NB_KEY-1:0]     gen_bus;
  logic [2:0]            rcon_sel;

  function automatic logic [NB_WORD-1:0] sub_word(
    input logic [NB_WORD-1:0] w
  );
    logic [NB_WORD-1:0] r;
    r = '0;
    for (int b = 0; b < N_BYTES_WORD; b++) begin
      r[b*NB_BYTE +: NB_BYTE] = SBOX[w[b*NB_BYTE +: NB_BYTE]];
    end
    return r;
  endfunction

  function automatic logic [NB_WORD-1:0] rot_word(
    input logic [NB_WORD-1:0] w
  );
    return {w[NB_WORD-NB_BYTE-1:0], w[NB_WORD-1 -: NB_BYTE]};
  endfunction

  function automatic logic [NB_BYTE-1:0] rcon(
    input logic [2:0] n
  );
    logic [NB_BYTE-1:0] r;
    case (n)
      3'd1:    r = 8'h01;
      3'd2:    r = 8'h02;
      3'd3:    r = 8'h04;
      3'd4:    r = 8'h08;
      3'd5:    r = 8'h10;
      3'd6:    r = 8'h20;
      3'd7:    r = 8'h40;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // words w[k+3..k+7]: everything the backward step reads
  assign src = window[NB_SRC-1:0];

  // regenerate w[k-4..k-1]; only the first word is non-linear
  always_comb begin
    t_first  = '0;
    gen_bus  = '0;
    rcon_sel = 3'(index >> 1);
    for (int j = 0; j < N_KW; j++) begin
      gen[j] = '0;
    end
    unique case (1'b1)
      index[0]: begin
        t_first = sub_word(src[NB_SRC-1 -: NB_WORD]);
      end
      !index[0]: begin
        t_first = sub_word(rot_word(src[NB_SRC-1 -: NB_WORD]))
                ^ {rcon(rcon_sel), {(NB_WORD-NB_BYTE){1'b0}}};
      end
    endcase
    gen[0] = src[NB_SRC-NB_WORD-1 -: NB_WORD] ^ t_first;
    for (int j = 1; j < N_KW; j++) begin
      gen[j] = src[NB_SRC-(j+1)*NB_WORD-1 -: NB_WORD]
             ^ src[NB_SRC-j*NB_WORD-1 -: NB_WORD];
    end
    for (int j = 0; j < N_KW; j++) begin
      gen_bus[NB_KEY-1-j*NB_WORD -: NB_WORD] = gen[j];
    end
  end

  // sequence control: load wins over a handshake, reset wins over all
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state  <= IDLE;
      window <= '0;
      index  <= '0;
      valid  <= 1'b0;
      last   <= 1'b0;
    end else if (i_load) begin
      state  <= RUN;
      window <= i_key_tail_bus;
      index  <= NB_INDEX'(N_ROUNDS);
      valid  <= 1'b1;
      last   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          valid <= 1'b0;
          last  <= 1'b0;
        end
        RUN: begin
          if (i_ready) begin
            if (index == '0) begin
              state <= IDLE;
              valid <= 1'b0;
              last  <= 1'b0;
            end else begin
              index  <= index - NB_INDEX'(1);
              window <= {gen_bus, window[NB_WIN-1 -: NB_KEY]};
              last   <= (index == NB_INDEX'(1));
            end
          end
        end
      endcase
    end
  end

  assign o_round_key   = window[NB_KEY-1:0];
  assign o_round_index = index;
  assign o_valid       = valid;
  assign o_last        = last;

endmodule

// File: tb/tb_key_scheduler_inverse_sequential.sv
// Bench for the inverse AES-256 key scheduler, checked against
// a forward key expansion with an S-box derived from GF(2^8).
module tb_key_scheduler_inverse_sequential;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [255:0] tail;
  logic         ready;
  logic [127:0] rkey;
  logic [3:0]   ridx;
  logic         valid;
  logic         last;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]   sbox_ref [256];
  logic [31:0]  ref_w [60];
  logic [127:0] got_key [15];

  localparam logic [255:0] KEY_A =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY_B =
    256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;

  key_scheduler_inverse_sequential dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_load         (load),
    .i_key_tail_bus (tail),
    .i_ready        (ready),
    .o_round_key    (rkey),
    .o_round_index  (ridx),
    .o_valid        (valid),
    .o_last         (last)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_ref[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2)
                  ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_w(input logic [31:0] w);
    return {sbox_ref[w[31:24]], sbox_ref[w[23:16]],
            sbox_ref[w[15:8]], sbox_ref[w[7:0]]};
  endfunction

  task automatic expand_key(input logic [255:0] key);
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 8; i++) ref_w[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = ref_w[i-1];
      if (i % 8 == 0) begin
        t = sub_w({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (i % 8 == 4) begin
        t = sub_w(t);
      end
      ref_w[i] = ref_w[i-8] ^ t;
    end
  endtask

  function automatic logic [127:0] exp_key(input int r);
    return {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
  endfunction

  function automatic logic roll(input int pct);
    return ($urandom_range(0, 99) < pct);
  endfunction

  // Starts and ends on a falling edge. stop_after>=0 returns early
  // after that many handshakes, leaving the sequence running.
  task automatic drive_sequence(input logic [255:0] key, input int pct,
                                input int stop_after);
    int  exp_r;
    int  hs;
    int  cyc;
    bit  done;
    expand_key(key);
    load  = 1'b1;
    tail  = {ref_w[52], ref_w[53], ref_w[54], ref_w[55],
             ref_w[56], ref_w[57], ref_w[58], ref_w[59]};
    ready = roll(pct);
    @(negedge clk);
    load  = 1'b0;
    exp_r = 14;
    hs    = 0;
    cyc   = 0;
    done  = 1'b0;
    while (!done) begin
      if (cyc > 2000) begin
        n_cmp++;
        n_err++;
        $display("FAIL seq_timeout: got %0d handshakes want 15", hs);
        ready = 1'b0;
        return;
      end
      n_cmp++;
      got_key[exp_r] = rkey;
      if ({valid, last, ridx, rkey} !==
          {1'b1, exp_r == 0, 4'(exp_r), exp_key(exp_r)}) begin
        n_err++;
        $display("FAIL seq_r%0d: got v=%b l=%b idx=%0d key=%h want v=1 l=%b idx=%0d key=%h",
                 exp_r, valid, last, ridx, rkey,
                 exp_r == 0, exp_r, exp_key(exp_r));
      end
      if (stop_after >= 0 && hs == stop_after) begin
        ready = 1'b0;
        return;
      end
      ready = roll(pct);
      if (ready) begin
        hs++;
        if (exp_r == 0) done = 1'b1;
        else exp_r--;
      end
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (valid !== 1'b0 || last !== 1'b0) begin
      n_err++;
      $display("FAIL seq_end: got v=%b l=%b want v=0 l=0", valid, last);
    end
    ready = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    load  = 1'b1;
    ready = 1'b1;
    tail  = {$urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({valid, last, ridx, rkey} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got v=%b l=%b idx=%0d key=%h want all 0",
               valid, last, ridx, rkey);
    end
    rst   = 1'b0;
    load  = 1'b0;
    ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: got v=%b want 0", valid);
    end
  endtask

  task automatic test_basic();
    drive_sequence(KEY_A, 100, -1);
    n_cmp++;
    if (got_key[14] !== 128'h24fc79ccbf0979e9371ac23c6d68de36) begin
      n_err++;
      $display("FAIL basic_r14: got %h want 24fc79ccbf0979e9371ac23c6d68de36",
               got_key[14]);
    end
    n_cmp++;
    if (got_key[1] !== 128'h101112131415161718191a1b1c1d1e1f) begin
      n_err++;
      $display("FAIL basic_r1: got %h want 101112131415161718191a1b1c1d1e1f",
               got_key[1]);
    end
    n_cmp++;
    if (got_key[0] !== 128'h000102030405060708090a0b0c0d0e0f) begin
      n_err++;
      $display("FAIL basic_r0: got %h want 000102030405060708090a0b0c0d0e0f",
               got_key[0]);
    end
  endtask

  task automatic test_backpressure();
    drive_sequence(KEY_A, 30, -1);
    n_cmp++;
    if (got_key[14] !== 128'h24fc79ccbf0979e9371ac23c6d68de36) begin
      n_err++;
      $display("FAIL bp_r14: got %h want 24fc79ccbf0979e9371ac23c6d68de36",
               got_key[14]);
    end
  endtask

  task automatic test_reload();
    drive_sequence(KEY_A, 100, 5);
    drive_sequence(KEY_B, 100, -1);
  endtask

  task automatic test_reset_mid();
    drive_sequence(KEY_B, 100, 7);
    rst   = 1'b1;
    load  = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({valid, last, ridx, rkey} !== '0) begin
      n_err++;
      $display("FAIL reset_mid: got v=%b l=%b idx=%0d key=%h want all 0",
               valid, last, ridx, rkey);
    end
    rst   = 1'b0;
    load  = 1'b0;
    ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_load_ignored: got v=%b want 0", valid);
    end
    drive_sequence(KEY_A, 100, -1);
    n_cmp++;
    if (got_key[0] !== 128'h000102030405060708090a0b0c0d0e0f) begin
      n_err++;
      $display("FAIL reset_mid_r0: got %h want 000102030405060708090a0b0c0d0e0f",
               got_key[0]);
    end
  endtask

  task automatic test_regression();
    logic [255:0] key;
    for (int n = 0; n < 1000; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom};
      drive_sequence(key, $urandom_range(30, 100), -1);
    end
  endtask

  initial begin
    rst   = 1'b1;
    load  = 1'b0;
    ready = 1'b0;
    tail  = '0;
    build_sbox();
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_reload();
    test_reset_mid();
    test_regression();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
